// File: rtl/ant_swarm_draw.sv
// rtl/ant_swarm_draw.sv - per-frame ant renderer: loads x/y per ant, optionally erases the old pixel, plots the new one
module ant_swarm_draw #(
  parameter int         N_ANTS            = 8,
  parameter int         MEM_ADDR_WIDTH    = 16,
  parameter int         ADDR_STRIDE       = 1,
  parameter int         COORD_WIDTH       = 8,
  parameter logic [2:0] ANT_COLOUR        = 3'b010,
  parameter logic [2:0] BG_COLOUR         = 3'b000,
  parameter int         RESULT_WIDTH      = 16,
  parameter int         INSTRUCTION_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         erase_en,
  input  logic [MEM_ADDR_WIDTH-1:0]    x_base,
  input  logic [MEM_ADDR_WIDTH-1:0]    y_base,
  output logic                         busy,
  output logic                         finished,
  input  logic                         finished_dp,
  input  logic [RESULT_WIDTH-1:0]      result_dp,
  output logic                         start_dp,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_dp
);

  localparam int IDX_W = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ANTS - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] STRIDE = MEM_ADDR_WIDTH'(ADDR_STRIDE);
  localparam int PLOT_BIT = 2 * COORD_WIDTH + 3;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] LDX_ISSUE = 4'd1;
  localparam logic [3:0] LDX_WAIT  = 4'd2;
  localparam logic [3:0] LDY_ISSUE = 4'd3;
  localparam logic [3:0] LDY_WAIT  = 4'd4;
  localparam logic [3:0] ER_ISSUE  = 4'd5;
  localparam logic [3:0] ER_WAIT   = 4'd6;
  localparam logic [3:0] DR_ISSUE  = 4'd7;
  localparam logic [3:0] DR_WAIT   = 4'd8;
  localparam logic [3:0] NEXT      = 4'd9;
  localparam logic [3:0] DONE      = 4'd10;

  logic [3:0]                state;
  logic [IDX_W-1:0]          index;
  logic                      erase_latched;
  logic [MEM_ADDR_WIDTH-1:0] x_base_latched;
  logic [MEM_ADDR_WIDTH-1:0] y_base_latched;
  logic [COORD_WIDTH-1:0]    cur_x;
  logic [COORD_WIDTH-1:0]    cur_y;
  logic [COORD_WIDTH-1:0]    prev_x [N_ANTS];
  logic [COORD_WIDTH-1:0]    prev_y [N_ANTS];
  logic [N_ANTS-1:0]         prev_valid;
  logic [MEM_ADDR_WIDTH-1:0] addr_offset;
  logic [MEM_ADDR_WIDTH-1:0] x_addr;
  logic [MEM_ADDR_WIDTH-1:0] y_addr;

  // Address arithmetic deliberately truncates to the memory width so bases near the top wrap.
  assign addr_offset = MEM_ADDR_WIDTH'(index) * STRIDE;
  assign x_addr      = x_base_latched + addr_offset;
  assign y_addr      = y_base_latched + addr_offset;

  assign start_dp = (state == LDX_ISSUE) || (state == LDY_ISSUE) ||
                    (state == ER_ISSUE)  || (state == DR_ISSUE);

  function automatic logic [INSTRUCTION_WIDTH-1:0] load_instr(input logic [MEM_ADDR_WIDTH-1:0] addr);
    logic [INSTRUCTION_WIDTH-1:0] word;
    word = '0;
    word[INSTRUCTION_WIDTH-1 -: 4] = 4'd2;
    word[MEM_ADDR_WIDTH-1:0]       = addr;
    return word;
  endfunction

  function automatic logic [INSTRUCTION_WIDTH-1:0] plot_instr(input logic [2:0] colour,
                                                              input logic [COORD_WIDTH-1:0] y,
                                                              input logic [COORD_WIDTH-1:0] x);
    logic [INSTRUCTION_WIDTH-1:0] word;
    word = '0;
    word[INSTRUCTION_WIDTH-1 -: 4]     = 4'd1;
    word[PLOT_BIT]                     = 1'b1;
    word[PLOT_BIT-1 -: 3]              = colour;
    word[2*COORD_WIDTH-1 -: COORD_WIDTH] = y;
    word[COORD_WIDTH-1:0]              = x;
    return word;
  endfunction

  // Instruction is decoded from state so it stays stable from issue through the matching wait.
  always_comb begin
    instruction_dp = '0;
    case (state)
      LDX_ISSUE, LDX_WAIT: instruction_dp = load_instr(x_addr);
      LDY_ISSUE, LDY_WAIT: instruction_dp = load_instr(y_addr);
      ER_ISSUE, ER_WAIT:   instruction_dp = plot_instr(BG_COLOUR, prev_y[index], prev_x[index]);
      DR_ISSUE, DR_WAIT:   instruction_dp = plot_instr(ANT_COLOUR, cur_y, cur_x);
      default:             instruction_dp = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= IDLE;
      index          <= '0;
      busy           <= 1'b0;
      finished       <= 1'b0;
      prev_valid     <= '0;
      erase_latched  <= 1'b0;
      x_base_latched <= '0;
      y_base_latched <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= LDX_ISSUE;
            busy           <= 1'b1;
            erase_latched  <= erase_en;
            x_base_latched <= x_base;
            y_base_latched <= y_base;
          end
        end
        LDX_ISSUE: state <= LDX_WAIT;
        LDX_WAIT: begin
          if (finished_dp) begin
            cur_x <= result_dp[COORD_WIDTH-1:0];
            state <= LDY_ISSUE;
          end
        end
        LDY_ISSUE: state <= LDY_WAIT;
        LDY_WAIT: begin
          if (finished_dp) begin
            cur_y <= result_dp[COORD_WIDTH-1:0];
            state <= (erase_latched && prev_valid[index]) ? ER_ISSUE : DR_ISSUE;
          end
        end
        ER_ISSUE: state <= ER_WAIT;
        ER_WAIT:  if (finished_dp) state <= DR_ISSUE;
        DR_ISSUE: state <= DR_WAIT;
        DR_WAIT:  if (finished_dp) state <= NEXT;
        NEXT: begin
          prev_valid[index] <= 1'b1;
          if (index == LAST_IDX) begin
            index    <= '0;
            state    <= DONE;
            finished <= 1'b1;
            busy     <= 1'b0;
          end else begin
            index <= index + 1'b1;
            state <= LDX_ISSUE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Position history needs no reset: prev_valid gates every use of it.
  always_ff @(posedge clock) begin
    if (resetn && state == NEXT) begin
      prev_x[index] <= cur_x;
      prev_y[index] <= cur_y;
    end
  end

endmodule

// File: tb/tb_ant_swarm_draw.sv
// tb/tb_ant_swarm_draw.sv - self-checking bench for ant_swarm_draw with a behavioural datapath and frame model
module tb_ant_swarm_draw;

  localparam int N = 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        erase_en = 1'b0;
  logic [15:0] x_base = '0;
  logic [15:0] y_base = '0;
  logic        busy;
  logic        finished;
  logic        finished_dp = 1'b0;
  logic [15:0] result_dp = '0;
  logic        start_dp;
  logic [31:0] instruction_dp;

  ant_swarm_draw #(.N_ANTS(N)) dut (
    .clock(clock), .resetn(resetn), .start(start), .erase_en(erase_en),
    .x_base(x_base), .y_base(y_base), .busy(busy), .finished(finished),
    .finished_dp(finished_dp), .result_dp(result_dp),
    .start_dp(start_dp), .instruction_dp(instruction_dp)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  int          stall = 0;
  logic [15:0] mem_off = '0;
  int          pending = 0;
  logic [31:0] cap_instr = '0;
  logic        start_dp_prev = 1'b0;
  int          stab_err = 0, start_err = 0, extra_err = 0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  bit          m_valid[N];
  logic [7:0]  m_px[N];
  logic [7:0]  m_py[N];

  // Datapath: completes each op stall+1 cycles after issue; loads return addr+mem_off.
  always @(negedge clock) begin
    finished_dp = 1'b0;
    if (pending > 0) begin
      if (instruction_dp !== cap_instr) stab_err++;
      pending--;
      if (pending == 0) begin
        finished_dp = 1'b1;
        result_dp = (cap_instr[31:28] == 4'd2) ? cap_instr[15:0] + mem_off : 16'($urandom);
      end
    end
    if (start_dp === 1'b1) begin
      if (start_dp_prev) start_err++;
      if (pending != 0) extra_err++;
      obs_q.push_back(instruction_dp);
      cap_instr = instruction_dp;
      pending = stall + 1;
    end
    start_dp_prev = start_dp;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [31:0] ld(input logic [15:0] a);
    return {4'd2, 12'd0, a};
  endfunction

  function automatic logic [31:0] pl(input logic [2:0] c, input logic [7:0] y, input logic [7:0] x);
    return {4'd1, 8'd0, 1'b1, c, y, x};
  endfunction

  // Expected instruction stream and start..finished cycle count (inclusive) for one frame.
  function automatic int build_model(input logic [15:0] xb, input logic [15:0] yb, input bit er);
    int cycles = 2;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      logic [15:0] xa, ya, rx, ry;
      bit e;
      xa = xb + 16'(i);
      ya = yb + 16'(i);
      rx = xa + mem_off;
      ry = ya + mem_off;
      e = er && m_valid[i];
      exp_q.push_back(ld(xa));
      exp_q.push_back(ld(ya));
      if (e) exp_q.push_back(pl(3'b000, m_py[i], m_px[i]));
      exp_q.push_back(pl(3'b010, ry[7:0], rx[7:0]));
      cycles += 7 + 2 * int'(e) + (3 + int'(e)) * stall;
      m_valid[i] = 1'b1;
      m_px[i] = rx[7:0];
      m_py[i] = ry[7:0];
    end
    return cycles;
  endfunction

  task automatic run_frame(input logic [15:0] xb, input logic [15:0] yb, input bit er,
                           input int stl, input logic [15:0] off, input bit poke);
    int exp_cycles, cyc, busy_bad, idle_bad;
    stall = stl;
    mem_off = off;
    exp_cycles = build_model(xb, yb, er);
    step();
    obs_q.delete();
    stab_err = 0; start_err = 0; extra_err = 0;
    x_base = xb; y_base = yb; erase_en = er; start = 1'b1;
    cyc = 1;
    busy_bad = 0;
    while (cyc < 2000) begin
      step();
      cyc++;
      if (cyc == 2) begin
        start = 1'b0;
        erase_en = ~er;
        x_base = 16'($urandom);
        y_base = 16'($urandom);
      end
      if (poke && cyc == 6) start = 1'b1;
      if (poke && cyc == 7) start = 1'b0;
      if (finished === 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
    end
    chk("finished_seen", 32'(finished), 32'd1);
    chk("frame_cycles", 32'(cyc), 32'(exp_cycles));
    chk("busy_low_at_finish", 32'(busy), 32'd0);
    chk("busy_during_frame", 32'(busy_bad), 32'd0);
    if (poke) start = 1'b1;
    step();
    start = 1'b0;
    chk("finished_one_pulse", 32'(finished), 32'd0);
    idle_bad = 0;
    repeat (4) begin
      step();
      if (start_dp !== 1'b0 || busy !== 1'b0 || finished !== 1'b0) idle_bad++;
    end
    chk("idle_after_frame", 32'(idle_bad), 32'd0);
    chk("instr_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("instr[%0d]", i), obs_q[i], exp_q[i]);
    chk("instr_stable", 32'(stab_err), 32'd0);
    chk("start_dp_one_cycle", 32'(start_err), 32'd0);
    chk("no_extra_issue", 32'(extra_err), 32'd0);
  endtask

  initial begin
    int n, fdp_seen, bad;
    resetn = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_start_dp", 32'(start_dp), 32'd0);
    chk("rst_instr", instruction_dp, 32'd0);
    resetn = 1'b1;
    step();

    run_frame(16'd16, 16'd32, 1'b1, 0, 16'd0, 1'b0);
    run_frame(16'd16, 16'd32, 1'b1, 0, 16'd1, 1'b1);
    run_frame(16'd16, 16'd32, 1'b1, 5, 16'd7, 1'b0);
    run_frame(16'hFFFF, 16'h0100, 1'b0, 0, 16'd0, 1'b0);
    chk("wrap_x_addr", obs_q.size() > 3 ? obs_q[3] : 32'hDEAD_BEEF, 32'h2000_0000);

    // Abort a frame while it waits on the y load.
    stall = 5;
    step();
    obs_q.delete();
    x_base = 16'h0040; y_base = 16'h0050; erase_en = 1'b1; start = 1'b1;
    n = 0;
    for (int k = 0; k < 100 && n < 2; k++) begin
      step();
      start = 1'b0;
      if (start_dp === 1'b1) n++;
    end
    chk("reached_ldy_issue", 32'(n), 32'd2);
    step();
    resetn = 1'b0;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_finished", 32'(finished), 32'd0);
    chk("midrst_start_dp", 32'(start_dp), 32'd0);
    chk("midrst_instr", instruction_dp, 32'd0);
    resetn = 1'b1;
    fdp_seen = 0;
    bad = 0;
    repeat (10) begin
      step();
      if (finished_dp === 1'b1) fdp_seen++;
      if (start_dp !== 1'b0 || busy !== 1'b0 || finished !== 1'b0) bad++;
    end
    chk("late_finished_dp_seen", 32'(fdp_seen), 32'd1);
    chk("late_finished_dp_ignored", 32'(bad), 32'd0);
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    run_frame(16'h0040, 16'h0050, 1'b1, 0, 16'd3, 1'b0);

    for (int r = 0; r < 6; r++)
      run_frame(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                16'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
